desc_queue_arb_ctrl: RTL and testbench

//  Controller that shares one small descriptor queue between two producers and drains it to one consumer.

---
 rtl/desc_queue_pkg.sv | 8 +
 rtl/dual_port_asyncout_ram.sv | 25 ++
 rtl/desc_queue_arb_ctrl.sv | 94 +++++++++
 tb/tb_desc_queue_arb_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/desc_queue_pkg.sv
// Shared defaults for the descriptor queue controller and its storage.
// Producer indices are used directly as the round-robin state value.
package desc_queue_pkg;
  localparam int DESC_W   = 11;
  localparam int QUEUE_AW = 2;
  localparam bit P0       = 1'b0;
  localparam bit P1       = 1'b1;
endpackage

// File: rtl/dual_port_asyncout_ram.sv
// Simple-dual-port distributed RAM: registered write, asynchronous read.
// No reset on contents; the controller's occupancy decides what is valid.
module dual_port_asyncout_ram
  import desc_queue_pkg::*;
#(
  parameter int D_WIDTH = DESC_W,
  parameter int A_WIDTH = QUEUE_AW
) (
  input  logic               clk,
  input  logic               we,
  input  logic [A_WIDTH-1:0] write_addr,
  input  logic [D_WIDTH-1:0] data,
  input  logic [A_WIDTH-1:0] read_addr,
  output logic [D_WIDTH-1:0] q
);

  logic [D_WIDTH-1:0] mem [2**A_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[write_addr] <= data;
  end

  assign q = mem[read_addr];

endmodule

// File: rtl/desc_queue_arb_ctrl.sv
// Two-producer, one-consumer descriptor queue with round-robin write arbitration.
// First-word-fall-through head; full/empty come from the level counter only.
module desc_queue_arb_ctrl
  import desc_queue_pkg::*;
#(
  parameter int D_WIDTH = DESC_W,
  parameter int A_WIDTH = QUEUE_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               p0_valid,
  input  logic [D_WIDTH-1:0] p0_data,
  output logic               p0_ready,
  input  logic               p1_valid,
  input  logic [D_WIDTH-1:0] p1_data,
  output logic               p1_ready,
  output logic               c_valid,
  output logic [D_WIDTH-1:0] c_data,
  input  logic               c_ready,
  output logic [A_WIDTH:0]   level,
  output logic               full
);

  localparam logic [A_WIDTH:0] LVL_FULL = {1'b1, {A_WIDTH{1'b0}}};

  logic [A_WIDTH-1:0] wr_ptr;
  logic [A_WIDTH-1:0] rd_ptr;
  logic [A_WIDTH:0]   level_q;
  logic               rr_last;

  logic               gnt_vld;
  logic               gnt_idx;
  logic               can_push;
  logic               push;
  logic               pop;
  logic [D_WIDTH-1:0] push_data;

  assign full    = (level_q == LVL_FULL);
  assign c_valid = (level_q != '0);
  assign level   = level_q;

  // Round-robin: on a tie the producer that did not push last wins.
  always_comb begin
    gnt_vld = p0_valid | p1_valid;
    gnt_idx = P0;
    if (p0_valid && p1_valid) gnt_idx = (rr_last == P0) ? P1 : P0;
    else if (p1_valid)        gnt_idx = P1;
  end

  assign can_push  = gnt_vld & ~full & ~rst & ~flush;
  assign p0_ready  = can_push & (gnt_idx == P0);
  assign p1_ready  = can_push & (gnt_idx == P1);
  assign push      = (p0_valid & p0_ready) | (p1_valid & p1_ready);
  assign pop       = c_valid & c_ready & ~flush;
  assign push_data = (gnt_idx == P1) ? p1_data : p0_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      rr_last <= P1;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + A_WIDTH'(1);
        rr_last <= gnt_idx;
      end
      if (pop) rd_ptr <= rd_ptr + A_WIDTH'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + (A_WIDTH+1)'(1);
        2'b01:   level_q <= level_q - (A_WIDTH+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  dual_port_asyncout_ram #(
    .D_WIDTH (D_WIDTH),
    .A_WIDTH (A_WIDTH)
  ) u_ram (
    .clk        (clk),
    .we         (push),
    .write_addr (wr_ptr),
    .data       (push_data),
    .read_addr  (rd_ptr),
    .q          (c_data)
  );

endmodule

// File: tb/tb_desc_queue_arb_ctrl.sv
// Directed bench for desc_queue_arb_ctrl: reset, fill/drain, arbitration,
// full-with-pop, pointer wrap and flush.
module tb_desc_queue_arb_ctrl;

  localparam int DW = 11;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          p0_valid, p1_valid;
  logic [DW-1:0] p0_data, p1_data;
  logic          p0_ready, p1_ready;
  logic          c_valid;
  logic [DW-1:0] c_data;
  logic          c_ready;
  logic [AW:0]   level;
  logic          full;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  desc_queue_arb_ctrl #(.D_WIDTH(DW), .A_WIDTH(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .p0_valid (p0_valid),
    .p0_data  (p0_data),
    .p0_ready (p0_ready),
    .p1_valid (p1_valid),
    .p1_data  (p1_data),
    .p1_ready (p1_ready),
    .c_valid  (c_valid),
    .c_data   (c_data),
    .c_ready  (c_ready),
    .level    (level),
    .full     (full)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] exp_q [4];
  logic [DW-1:0] model [$];
  bit push_pat [16] = '{1,1,0,1,1,0,0,1,1,1,0,1,1,0,1,0};
  bit pop_pat  [16] = '{0,0,1,1,0,1,1,0,1,0,1,1,1,1,0,1};

  initial begin
    int k;
    rst = 1'b1; flush = 1'b0; c_ready = 1'b0;
    p0_valid = 1'b1; p1_valid = 1'b1; p0_data = 11'h7AA; p1_data = 11'h755;

    // reset: both producers valid, nobody may be accepted
    tick(); #1;
    chk("rst_p0_ready_c1", 32'(p0_ready), 32'd0);
    chk("rst_p1_ready_c1", 32'(p1_ready), 32'd0);
    tick(); #1;
    chk("rst_p0_ready_c2", 32'(p0_ready), 32'd0);
    chk("rst_p1_ready_c2", 32'(p1_ready), 32'd0);
    rst = 1'b0; p0_valid = 1'b0; p1_valid = 1'b0;
    #1;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_c_valid", 32'(c_valid), 32'd0);
    chk("rst_full", 32'(full), 32'd0);

    // fill from p0, then drain in order
    for (int i = 1; i <= 4; i++) begin
      p0_valid = 1'b1; p0_data = DW'(i);
      #1;
      chk("fill_p0_ready", 32'(p0_ready), 32'd1);
      tick();
      chk("fill_level", 32'(level), 32'(i));
    end
    chk("fill_full", 32'(full), 32'd1);
    p0_data = 11'h005;
    #1;
    chk("full_p0_ready", 32'(p0_ready), 32'd0);
    tick();
    chk("full_hold_level", 32'(level), 32'd4);
    p0_valid = 1'b0; c_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("drain_c_valid", 32'(c_valid), 32'd1);
      chk("drain_c_data", 32'(c_data), 32'(i));
      tick();
    end
    c_ready = 1'b0;
    chk("drain_empty", 32'(c_valid), 32'd0);
    chk("drain_level", 32'(level), 32'd0);

    // fresh reset so p0 wins the first tie, then alternate
    rst = 1'b1; tick(); rst = 1'b0;
    exp_q = '{11'h100, 11'h200, 11'h101, 11'h201};
    p0_valid = 1'b1; p1_valid = 1'b1; c_ready = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      p0_data = DW'(11'h100 + (cyc + 1) / 2);
      p1_data = DW'(11'h200 + cyc / 2);
      #1;
      chk("rr_p0_ready", 32'(p0_ready), 32'(cyc % 2 == 0));
      chk("rr_p1_ready", 32'(p1_ready), 32'(cyc % 2 == 1));
      if (cyc > 0) chk("rr_c_data", 32'(c_data), 32'(exp_q[cyc-1]));
      tick();
    end
    p0_valid = 1'b0; p1_valid = 1'b0;
    #1;
    chk("rr_last_c_data", 32'(c_data), 32'(exp_q[3]));
    tick();
    c_ready = 1'b0;
    chk("rr_level_end", 32'(level), 32'd0);

    // full with simultaneous pop: push deferred one cycle
    p1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      p1_data = DW'(11'h300 + i);
      tick();
    end
    chk("fp_full", 32'(full), 32'd1);
    p1_data = 11'h304; c_ready = 1'b1;
    #1;
    chk("fp_p1_ready_full", 32'(p1_ready), 32'd0);
    chk("fp_head", 32'(c_data), 32'h300);
    tick();
    chk("fp_level_after_pop", 32'(level), 32'd3);
    c_ready = 1'b0;
    #1;
    chk("fp_p1_ready_next", 32'(p1_ready), 32'd1);
    tick();
    p1_valid = 1'b0;
    chk("fp_level_refill", 32'(level), 32'd4);
    c_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("fp_drain_data", 32'(c_data), 32'(11'h300 + i));
      tick();
    end
    c_ready = 1'b0;
    chk("fp_drain_level", 32'(level), 32'd0);

    // pointer wrap with level oscillating 0..2
    k = 0;
    model.delete();
    for (int cyc = 0; cyc < 16; cyc++) begin
      p0_valid = push_pat[cyc];
      p0_data  = DW'(11'h400 + k);
      c_ready  = pop_pat[cyc];
      #1;
      chk("wrap_level", 32'(level), 32'(model.size()));
      chk("wrap_c_valid", 32'(c_valid), 32'(model.size() != 0));
      if (model.size() != 0) chk("wrap_c_data", 32'(c_data), 32'(model[0]));
      if (push_pat[cyc]) chk("wrap_p0_ready", 32'(p0_ready), 32'd1);
      tick();
      if (pop_pat[cyc] && model.size() != 0) void'(model.pop_front());
      if (push_pat[cyc]) begin
        model.push_back(DW'(11'h400 + k));
        k++;
      end
    end
    p0_valid = 1'b0; c_ready = 1'b0;
    chk("wrap_end_level", 32'(level), 32'd0);

    // flush at level 3 with push and pop requested; rr_last survives
    p0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      p0_data = DW'(11'h500 + i);
      tick();
    end
    chk("fl_level_pre", 32'(level), 32'd3);
    flush = 1'b1; p0_data = 11'h503; c_ready = 1'b1;
    #1;
    chk("fl_p0_ready", 32'(p0_ready), 32'd0);
    tick();
    flush = 1'b0; p0_valid = 1'b0; c_ready = 1'b0;
    #1;
    chk("fl_level_post", 32'(level), 32'd0);
    chk("fl_c_valid_post", 32'(c_valid), 32'd0);
    p0_valid = 1'b1; p1_valid = 1'b1; p0_data = 11'h600; p1_data = 11'h601;
    #1;
    chk("fl_rr_p1_ready", 32'(p1_ready), 32'd1);
    chk("fl_rr_p0_ready", 32'(p0_ready), 32'd0);
    tick();
    p0_valid = 1'b0; p1_valid = 1'b0;
    #1;
    chk("fl_rr_c_data", 32'(c_data), 32'h601);
    chk("fl_rr_level", 32'(level), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
